// File: rtl/tl_left_ctrl_pkg.sv
// Shared light codes, state codes and default timing constants for the intersection controller.
package tl_left_ctrl_pkg;

    localparam int DEF_MIN_GREEN = 3;
    localparam int DEF_YEL_CYC   = 2;
    localparam int DEF_TW        = 3;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        LEFT   = 2'b10,
        RED    = 2'b11
    } light_t;

    typedef enum logic [2:0] {
        S0 = 3'd0,  // A_GRN
        S1 = 3'd1,  // A_YEL1
        S2 = 3'd2,  // A_LEFT
        S3 = 3'd3,  // A_YEL2
        S4 = 3'd4,  // B_GRN
        S5 = 3'd5,  // B_YEL1
        S6 = 3'd6,  // B_LEFT
        S7 = 3'd7   // B_YEL2
    } state_t;

    typedef struct packed {
        light_t la;
        light_t lb;
    } lights_t;

    // Every state leaves at least one road RED, which is what keeps the junction safe.
    function automatic lights_t decode_lights(input state_t s);
        lights_t l;
        l = '{la: RED, lb: RED};
        case (s)
            S0:      l.la = GREEN;
            S1, S3:  l.la = YELLOW;
            S2:      l.la = LEFT;
            S4:      l.lb = GREEN;
            S5, S7:  l.lb = YELLOW;
            S6:      l.lb = LEFT;
            default: l = '{la: RED, lb: RED};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tl_left_ctrl_if.sv
// Sensor inputs and light/state outputs of the intersection controller.
interface tl_left_ctrl_if;
    import tl_left_ctrl_pkg::*;

    logic   ta;
    logic   tal;
    logic   tb;
    logic   tbl;
    light_t la;
    light_t lb;
    state_t state;

    modport master (
        output ta, tal, tb, tbl,
        input  la, lb, state
    );

    modport slave (
        input  ta, tal, tb, tbl,
        output la, lb, state
    );

endinterface

// File: rtl/tl_left_ctrl_reg3.sv
// Purpose: 3-bit state register with asynchronous active-low reset to S0.
// Latency: q follows d one clock later; reset acts immediately.
// Backpressure: none, loads every cycle.
module tl_left_ctrl_reg3 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] d,
    output logic [2:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= 3'd0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/tl_left_ctrl.sv
// Purpose: Moore sequencer for a two-road junction with a protected left phase per road.
// Latency: sensor sampled at a rising edge changes the lights right after that edge.
// Backpressure: none; sensors are level inputs, the current road holds until its sensor drops.
module tl_left_ctrl
    import tl_left_ctrl_pkg::*;
#(
    parameter int MIN_GREEN = DEF_MIN_GREEN,
    parameter int YEL_CYC   = DEF_YEL_CYC,
    parameter int TW        = DEF_TW
) (
    input  logic            clk,
    input  logic            reset_n,
    tl_left_ctrl_if.slave   bus
);

    localparam logic [TW-1:0] GRN_LAST = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] YEL_LAST = TW'(YEL_CYC - 1);
    localparam logic [TW-1:0] TMR_MAX  = {TW{1'b1}};

    logic [2:0]    state_q;
    state_t        cur;
    state_t        nxt;
    logic [TW-1:0] timer;
    lights_t       lights;

    tl_left_ctrl_reg3 u_register3_r (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (nxt),
        .q       (state_q)
    );

    assign cur = state_t'(state_q);

    always_comb begin
        nxt = cur;
        case (cur)
            S0:      if (!bus.ta && timer >= GRN_LAST) nxt = S1;
            S1:      if (timer == YEL_LAST)            nxt = S2;
            S2:      if (!bus.tal)                     nxt = S3;
            S3:      if (timer == YEL_LAST)            nxt = S4;
            S4:      if (!bus.tb && timer >= GRN_LAST) nxt = S5;
            S5:      if (timer == YEL_LAST)            nxt = S6;
            S6:      if (!bus.tbl)                     nxt = S7;
            S7:      if (timer == YEL_LAST)            nxt = S0;
            default: nxt = S0;
        endcase
    end

    // Dwell timer counts cycles spent in the current state; saturation keeps long greens exitable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (nxt != cur) begin
            timer <= '0;
        end else if (timer != TMR_MAX) begin
            timer <= timer + 1'b1;
        end
    end

    always_comb begin
        lights    = decode_lights(cur);
        bus.la    = lights.la;
        bus.lb    = lights.lb;
        bus.state = cur;
    end

endmodule
